sr_latch_bank: RTL and testbench
================================

Name: sr_latch_bank

Overview:
- Parametrised, clocked, multi-channel successor to the gate-level RS latch.
- Each channel is a synchronous SR storage element with:
  - an input glitch filter;
  - a run-time selectable resolution mode for the S=R=1 condition;
  - a sticky illegal-condition flag.
- Always-complementary q/q_bar; no metastable or both-low output state.
- Used as a bank of status/flag latches between asynchronous-ish control strobes and the clocked datapath.

Parameters:
- CHANNELS, 4: number of independent SR channels (>=1).
- FILTER, 2: extra consecutive cycles an input pair must stay stable before acceptance (0 = no filtering; max 15).
- CNT_W, 8: width of the optional illegal-event counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- set, input, CHANNELS: per-channel set request.
- reset, input, CHANNELS: per-channel reset request (data input, not the module reset).
- mode, input, 2: S=R=1 resolution. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- illegal_clr, input, CHANNELS: per-channel clear for the sticky illegal flag.
- q, output, CHANNELS: latch state.
- q_bar, output, CHANNELS: always ~q.
- changed, output, CHANNELS: 1-cycle pulse on the edge q[i] changes.
- illegal, output, CHANNELS: sticky flag; an S=R=1 pair was accepted.
- illegal_count, output, CNT_W: saturating illegal-event counter (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous): q=0, q_bar=all ones, changed=0, illegal=0, illegal_count=0, all sync/filter state=0. Outputs are held while reset_n is low. First evaluation occurs on the first rising edge after deassertion.
- Input stage per channel: {set[i],reset[i]} is registered every edge into samp[i].
- Filter per channel: 4-bit stable counter.
  - Cleared when the new sample differs from the previous sample.
  - Otherwise increments, saturating at FILTER.
  - The pair is accepted on the edge where counter == FILTER. FILTER=0 accepts every sample.
- Latency: if a pair is present at inputs on edges k..k+FILTER, q updates on edge k+FILTER+1. Any change inside that window restarts the window.
- Acceptance repeats every cycle while the pair stays stable, which matters for toggle mode.
- Action on accepted pair:
  - 00: hold.
  - 10: q=1.
  - 01: q=0.
  - 11, mode 0: hold.
  - 11, mode 1: q=1.
  - 11, mode 2: q=0.
  - 11, mode 3: q inverts every cycle the pair remains accepted.
- mode is sampled on the acceptance edge. A mode change takes effect on the next accepted 11.
- changed[i] = 1 for exactly the cycle following an edge on which q[i] changed value. It is registered and aligned with the new q.
- illegal[i]:
  - Set on any edge accepting 11 on channel i, regardless of mode.
  - Cleared by illegal_clr[i] on the next edge.
  - Simultaneous accept-11 and clr: set wins.
- Channels are fully independent; no cross-channel interaction except illegal_count.
- Reset mid-filter-window: window discarded; after release, counting restarts from a fresh sample.

Optional Feature:
- Macro: SR_LATCH_BANK_ILLEGAL_COUNT_EN.
- Defined:
  - illegal_count increments by 1 on each edge where at least one channel accepts 11.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared only by reset_n.
- Undefined: the port remains but is tied to 0. No counter logic is synthesised.

Test Plan (CHANNELS=4, FILTER=2 unless noted):
- Reset then idle: reset_n low, release, set=reset=0 for 10 cycles -> q=0000, q_bar=1111, changed=0000, illegal=0000 throughout.
- Filtered set: set[0]=1 held from edge k -> q[0]=1 at edge k+3, changed[0] pulses one cycle only. A 2-cycle set[1] glitch -> q[1] stays 0.
- Mode sweep on channel 2: q[2]=0, apply S=R=1 for 6 cycles in each mode:
  - mode 0 -> q stays 0;
  - mode 1 -> q=1;
  - mode 2 -> q=0;
  - mode 3 -> q toggles each cycle after acceptance, with changed[2] high each of those cycles.
- Illegal flag: accept 11 on channel 3 -> illegal[3]=1 and stays 1 after inputs return to 00. illegal_clr[3] pulse -> 0. Clr coincident with a new accepted 11 -> remains 1.
- FILTER=0 build: set[0] for one cycle -> q[0]=1 the next edge. Async reset asserted between clock edges -> q immediately 0 without a clock edge.
- With SR_LATCH_BANK_ILLEGAL_COUNT_EN, CNT_W=3: hold 11 on two channels for 10 cycles -> illegal_count increments once per cycle and saturates at 7. Without the macro -> illegal_count stays 0.

Source files
------------

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of clocked SR flag latches with per-channel input glitch
// filtering, selectable S=R=1 resolution, a sticky illegal flag per channel,
// and an optional saturating illegal-event counter.
//
// Optional feature macro: SR_LATCH_BANK_ILLEGAL_COUNT_EN
//   defined   -> illegal_count counts edges on which any channel accepts S=R=1
//   undefined -> illegal_count is tied to zero
//
// Channel datapath:
//   {set,reset} -> samp register -> stability counter -> accept -> q update
// A pair is accepted while the stability counter sits at FILTER. The counter
// restarts whenever the incoming pair differs from the one already sampled.
// This gives a pair present on edges k..k+FILTER a q update on edge k+FILTER+1.
// Acceptance repeats every cycle the pair stays stable, so toggle mode keeps
// inverting q for as long as S=R=1 is held.
`timescale 1ns/1ps

module sr_latch_bank #(
  parameter int CHANNELS = 4,
  parameter int FILTER   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] set,
  input  logic [CHANNELS-1:0] reset,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] illegal_clr,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_bar,
  output logic [CHANNELS-1:0] changed,
  output logic [CHANNELS-1:0] illegal,
  output logic [CNT_W-1:0]    illegal_count
);

  // Filter threshold as a 4-bit compare value; the counter never exceeds it.
  localparam logic [3:0] FILT = 4'(FILTER);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_SET   = 2'd1;
  localparam logic [1:0] MODE_RESET = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  logic [CHANNELS-1:0] accept_11;
  logic [CHANNELS-1:0] q_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0] pair_in;
    logic [1:0] samp;
    logic [3:0] stab_cnt;
    logic       accept;
    logic       q_nxt;

    assign pair_in = {set[i], reset[i]};

    // Input sampling and stability counting; a changed pair restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        samp     <= 2'b00;
        stab_cnt <= 4'd0;
      end else begin
        samp <= pair_in;
        if (pair_in != samp) begin
          stab_cnt <= 4'd0;
        end else if (stab_cnt != FILT) begin
          stab_cnt <= stab_cnt + 4'd1;
        end
      end
    end

    assign accept       = (stab_cnt == FILT);
    assign accept_11[i] = accept && (samp == 2'b11);

    // Next latch value for this channel from the accepted pair and mode.
    always_comb begin
      q_nxt = q[i];
      if (accept) begin
        case (samp)
          2'b10: q_nxt = 1'b1;
          2'b01: q_nxt = 1'b0;
          2'b11: begin
            case (mode)
              MODE_HOLD:   q_nxt = q[i];
              MODE_SET:    q_nxt = 1'b1;
              MODE_RESET:  q_nxt = 1'b0;
              MODE_TOGGLE: q_nxt = ~q[i];
              default:     q_nxt = q[i];
            endcase
          end
          default: q_nxt = q[i];
        endcase
      end
    end

    assign q_next[i] = q_nxt;
  end

  // Latch state, change pulse and sticky illegal flag; a new accepted 11 beats clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      changed <= '0;
      illegal <= '0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
      illegal <= accept_11 | (illegal & ~illegal_clr);
    end
  end

  assign q_bar = ~q;

`ifdef SR_LATCH_BANK_ILLEGAL_COUNT_EN
  // Saturating count of edges on which any channel accepted S=R=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_count <= '0;
    end else if ((|accept_11) && (illegal_count != {CNT_W{1'b1}})) begin
      illegal_count <= illegal_count + CNT_W'(1);
    end
  end
`else
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_sr_latch_bank.sv
`timescale 1ns/1ps

module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] set, reset, illegal_clr;
  logic [1:0] mode;
  logic [3:0] q, q_bar, changed, illegal;
  logic [2:0] illegal_count;

  logic [3:0] set_f0, reset_f0;
  logic [3:0] q_f0, q_bar_f0, changed_f0, illegal_f0;
  logic [7:0] illegal_count_f0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_latch_bank #(.CHANNELS(4), .FILTER(2), .CNT_W(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .set(set), .reset(reset), .mode(mode),
    .illegal_clr(illegal_clr), .q(q), .q_bar(q_bar), .changed(changed),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  sr_latch_bank #(.CHANNELS(4), .FILTER(0), .CNT_W(8)) u_f0 (
    .clk(clk), .reset_n(reset_n), .set(set_f0), .reset(reset_f0), .mode(mode),
    .illegal_clr(illegal_clr), .q(q_f0), .q_bar(q_bar_f0), .changed(changed_f0),
    .illegal(illegal_f0), .illegal_count(illegal_count_f0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold S=R=1 on one channel for six edges, then 00; check q/changed per edge.
  task automatic sweep(input int ch, input logic [1:0] m, input logic [7:0] eq,
                       input logic [7:0] ec, input string tag);
    mode      = m;
    set[ch]   = 1'b1;
    reset[ch] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("%s_q_%0d", tag, j), 32'(q[ch]), 32'(eq[j]));
      chk($sformatf("%s_chg_%0d", tag, j), 32'(changed[ch]), 32'(ec[j]));
      if (j == 5) begin
        set[ch]   = 1'b0;
        reset[ch] = 1'b0;
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    set         = '0;
    reset       = '0;
    illegal_clr = '0;
    mode        = 2'd0;
    set_f0      = '0;
    reset_f0    = '0;

    // reset state
    repeat (3) tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qbar", 32'(q_bar), 32'hF);
    chk("rst_changed", 32'(changed), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_count", 32'(illegal_count), 32'h0);
    reset_n = 1'b1;

    // idle
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("idle_q_%0d", j), 32'(q), 32'h0);
      chk($sformatf("idle_qbar_%0d", j), 32'(q_bar), 32'hF);
      chk($sformatf("idle_chg_%0d", j), 32'(changed), 32'h0);
      chk($sformatf("idle_ill_%0d", j), 32'(illegal), 32'h0);
    end

    // filtered set on channel 0: visible on edge k+3
    set[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("fset_wait_%0d", j), 32'(q), 32'h0);
    end
    tick();
    chk("fset_q", 32'(q), 32'h1);
    chk("fset_qbar", 32'(q_bar), 32'hE);
    chk("fset_chg", 32'(changed), 32'h1);
    set[0] = 1'b0;
    tick();
    chk("fset_chg_end", 32'(changed), 32'h0);
    chk("fset_hold", 32'(q), 32'h1);

    // two-cycle glitch on channel 1 is rejected
    set[1] = 1'b1;
    tick();
    tick();
    set[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("glitch_q_%0d", j), 32'(q), 32'h1);
      chk($sformatf("glitch_chg_%0d", j), 32'(changed), 32'h0);
    end

    // mode sweep on channel 2 (accepted on edges k+3..k+6)
    sweep(2, 2'd0, 8'h00, 8'h00, "m0");
    chk("m0_illegal", 32'(illegal), 32'h4);
    sweep(2, 2'd1, 8'hF8, 8'h08, "m1");
    sweep(2, 2'd2, 8'h07, 8'h08, "m2");
    sweep(2, 2'd3, 8'h28, 8'h78, "m3");
    chk("sweep_q0", 32'(q[0]), 32'h1);

    // sticky illegal flag on channel 3
    mode     = 2'd0;
    set[3]   = 1'b1;
    reset[3] = 1'b1;
    repeat (3) tick();
    set[3]   = 1'b0;
    reset[3] = 1'b0;
    tick();
    chk("ill_set", 32'(illegal[3]), 32'h1);
    repeat (3) tick();
    chk("ill_sticky", 32'(illegal[3]), 32'h1);
    illegal_clr[3] = 1'b1;
    tick();
    illegal_clr[3] = 1'b0;
    chk("ill_clr", 32'(illegal[3]), 32'h0);
    chk("ill_other", 32'(illegal[2]), 32'h1);

    // clear coincident with a new accepted 11: set wins
    set[3]   = 1'b1;
    reset[3] = 1'b1;
    repeat (3) tick();
    set[3]         = 1'b0;
    reset[3]       = 1'b0;
    illegal_clr[3] = 1'b1;
    tick();
    illegal_clr[3] = 1'b0;
    chk("ill_setwins", 32'(illegal[3]), 32'h1);
    tick();
    chk("ill_setwins_hold", 32'(illegal[3]), 32'h1);
    chk("ill_q", 32'(q), 32'h1);
    illegal_clr[3] = 1'b1;
    tick();
    illegal_clr[3] = 1'b0;
    chk("ill_clr2", 32'(illegal[3]), 32'h0);

    // FILTER=0 instance: one-cycle set appears on the next edge
    set_f0[0] = 1'b1;
    tick();
    set_f0[0] = 1'b0;
    chk("f0_before", 32'(q_f0), 32'h0);
    tick();
    chk("f0_q", 32'(q_f0), 32'h1);
    chk("f0_qbar", 32'(q_bar_f0), 32'hE);
    chk("f0_chg", 32'(changed_f0), 32'h1);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_qbar", 32'(q_bar), 32'hF);
    chk("arst_illegal", 32'(illegal), 32'h0);
    chk("arst_f0_q", 32'(q_f0), 32'h0);
    chk("arst_count", 32'(illegal_count), 32'h0);
    tick();
    reset_n = 1'b1;

    // S=R=1 on two channels: illegal counter behaviour
    mode       = 2'd0;
    set[1:0]   = 2'b11;
    reset[1:0] = 2'b11;
    for (int j = 0; j < 12; j++) begin
      int e;
      tick();
`ifdef SR_LATCH_BANK_ILLEGAL_COUNT_EN
      e = (j < 3) ? 0 : ((j - 2 > 7) ? 7 : j - 2);
`else
      e = 0;
`endif
      chk($sformatf("cnt_%0d", j), 32'(illegal_count), 32'(e));
    end
    chk("cnt_illegal", 32'(illegal), 32'h3);
    chk("cnt_q", 32'(q), 32'h0);
    set   = '0;
    reset = '0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
